// File: rtl/pm_fetch_queue_if.sv
// rtl/pm_fetch_queue_if.sv - PM read port and dual-issue decoder bundle for the fetch queue
interface pm_fetch_queue_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] pm_addr_rd;
    logic                  pm_rd_ins;
    logic [63:0]           pm_data_rd;
    logic                  pm_overflow;
    logic                  ins0_valid;
    logic [31:0]           ins0;
    logic [ADDR_WIDTH-1:0] ins0_pc;
    logic                  ins1_valid;
    logic [31:0]           ins1;
    logic [ADDR_WIDTH-1:0] ins1_pc;
    logic [1:0]            issue_cnt;
    logic                  redirect_en;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  misalign_err;

    modport master (
        input  fetch_en, pm_data_rd, pm_overflow, issue_cnt, redirect_en, redirect_pc,
        output pm_addr_rd, pm_rd_ins, ins0_valid, ins0, ins0_pc,
               ins1_valid, ins1, ins1_pc, misalign_err
    );

    modport slave (
        output fetch_en, pm_data_rd, pm_overflow, issue_cnt, redirect_en, redirect_pc,
        input  pm_addr_rd, pm_rd_ins, ins0_valid, ins0, ins0_pc,
               ins1_valid, ins1, ins1_pc, misalign_err
    );
endinterface

// File: rtl/pm_fetch_queue.sv
// rtl/pm_fetch_queue.sv - doubleword fetch from PM into a word queue feeding a dual-issue decoder
module pm_fetch_queue #(
    parameter int ADDR_DEPTH  = 2048,
    parameter int ADDR_WIDTH  = $clog2(ADDR_DEPTH),
    parameter int QUEUE_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    pm_fetch_queue_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]           ins_q [QUEUE_DEPTH];
    logic [31:0]           ins_d [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] ipc_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] ipc_d [QUEUE_DEPTH];

    logic                  halt;
    logic                  fetch;
    logic [CW-1:0]         free, issue_eff, push_n;
    logic [PW-1:0]         rd_ptr_n1, wr_ptr_n1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= ADDR_WIDTH'(RESET_PC);
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                ins_q[i] <= '0;
                ipc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ins_q    <= ins_d;
            ipc_q    <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.redirect_en) begin
            state_d = (bus.redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
        end
    end

    always_comb begin
        halt             = (state_q == ST_HALT);
        bus.misalign_err = halt;
    end

    // Free space is judged before this cycle's issue, so a full queue never fetches.
    always_comb begin
        free      = CW'(QUEUE_DEPTH) - count_q;
        issue_eff = (CW'(bus.issue_cnt) > count_q) ? count_q : CW'(bus.issue_cnt);
        fetch     = rst_n & bus.fetch_en & ~halt & ~bus.redirect_en & (free >= CW'(2));
        push_n    = !fetch ? CW'(0) : (bus.pm_overflow ? CW'(1) : CW'(2));
        wr_ptr_n1 = wr_ptr_q + PW'(1);
        rd_ptr_n1 = rd_ptr_q + PW'(1);
    end

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ins_d    = ins_q;
        ipc_d    = ipc_q;
        if (bus.redirect_en) begin
            pc_d     = bus.redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(issue_eff);
            wr_ptr_d = wr_ptr_q + PW'(push_n);
            count_d  = count_q - issue_eff + push_n;
            if (fetch) begin
                ins_d[wr_ptr_q] = bus.pm_data_rd[31:0];
                ipc_d[wr_ptr_q] = pc_q;
                if (bus.pm_overflow) begin
                    pc_d = '0;
                end else begin
                    ins_d[wr_ptr_n1] = bus.pm_data_rd[63:32];
                    ipc_d[wr_ptr_n1] = pc_q + ADDR_WIDTH'(4);
                    pc_d             = pc_q + ADDR_WIDTH'(8);
                end
            end
        end
    end

    // Invalid slots read as zero so stale entries never leak to the decoder.
    always_comb begin
        bus.pm_addr_rd = pc_q;
        bus.pm_rd_ins  = fetch;
        bus.ins0_valid = (count_q != '0);
        bus.ins1_valid = (count_q >= CW'(2));
        bus.ins0       = bus.ins0_valid ? ins_q[rd_ptr_q]  : '0;
        bus.ins0_pc    = bus.ins0_valid ? ipc_q[rd_ptr_q]  : '0;
        bus.ins1       = bus.ins1_valid ? ins_q[rd_ptr_n1] : '0;
        bus.ins1_pc    = bus.ins1_valid ? ipc_q[rd_ptr_n1] : '0;
    end
endmodule

// File: tb/tb_pm_fetch_queue.sv
// tb/tb_pm_fetch_queue.sv - directed and randomized checks of pm_fetch_queue against a queue model
module tb_pm_fetch_queue;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int QD    = 4;

    typedef struct {
        logic [31:0] w;
        int          pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    ent_t q[$];
    int   m_pc;
    bit   m_halt;

    pm_fetch_queue_if #(.ADDR_WIDTH(AW)) bus ();

    pm_fetch_queue #(
        .ADDR_DEPTH (DEPTH),
        .ADDR_WIDTH (AW),
        .QUEUE_DEPTH(QD),
        .RESET_PC   (0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pm_word(input logic [AW-1:0] a);
        if (a == 11'd0) return 32'h55667788;
        if (a == 11'd4) return 32'h11223344;
        return {5'h1A, a, 5'h0C, ~a};
    endfunction

    assign bus.pm_overflow = (bus.pm_addr_rd == AW'(DEPTH - 4));
    assign bus.pm_data_rd  = {bus.pm_overflow ? 32'hDEADBEEF : pm_word(bus.pm_addr_rd + AW'(4)),
                              pm_word(bus.pm_addr_rd)};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.fetch_en    = 1'b0;
        bus.issue_cnt   = 2'd0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_pm_rd_ins", bus.pm_rd_ins, 0);
        check("rst_pm_addr", bus.pm_addr_rd, 0);
        check("rst_ins0_valid", bus.ins0_valid, 0);
        check("rst_ins1_valid", bus.ins1_valid, 0);
        check("rst_ins0", {bus.ins0, 5'd0, bus.ins0_pc}, 0);
        check("rst_ins1", {bus.ins1, 5'd0, bus.ins1_pc}, 0);
        check("rst_misalign", bus.misalign_err, 0);
    endtask

    // Entered at posedge+1; asserts reset with fetching requested, releases on the negedge.
    task automatic do_reset();
        bus.fetch_en = 1'b1;
        rst_n        = 1'b0;
        #2;
        check_reset_outputs();
        q.delete();
        m_pc   = 0;
        m_halt = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic fe, input logic [1:0] ic, input logic re, input logic [AW-1:0] rpc);
        bit fetch;
        bus.fetch_en    = fe;
        bus.issue_cnt   = ic;
        bus.redirect_en = re;
        bus.redirect_pc = rpc;
        #2;
        assert (int'(ic) <= q.size());
        fetch = fe && !m_halt && !re && (QD - q.size() >= 2);
        check("pm_rd_ins", bus.pm_rd_ins, fetch);
        check("pm_addr_rd", bus.pm_addr_rd, m_pc);
        check("misalign_err", bus.misalign_err, m_halt);
        check("ins0_valid", bus.ins0_valid, q.size() >= 1);
        check("ins1_valid", bus.ins1_valid, q.size() >= 2);
        if (q.size() >= 1) check("ins0", {bus.ins0, 21'd0, bus.ins0_pc}, {q[0].w, 21'd0, 11'(q[0].pc)});
        if (q.size() >= 2) check("ins1", {bus.ins1, 21'd0, bus.ins1_pc}, {q[1].w, 21'd0, 11'(q[1].pc)});
        @(posedge clk);
        if (re) begin
            q.delete();
            m_pc   = int'(rpc);
            m_halt = (rpc[1:0] != 2'b00);
        end else begin
            repeat (int'(ic)) void'(q.pop_front());
            if (fetch) begin
                q.push_back('{w: pm_word(11'(m_pc)), pc: m_pc});
                if (m_pc == DEPTH - 4) begin
                    m_pc = 0;
                end else begin
                    q.push_back('{w: pm_word(11'((m_pc + 4) % DEPTH)), pc: m_pc + 4});
                    m_pc = (m_pc + 8) % DEPTH;
                end
            end
        end
        #1;
    endtask

    initial begin
        int          r;
        int          mx;
        logic [AW-1:0] rpc;

        idle_inputs();
        rst_n = 1'b0;
        #1;
        do_reset();

        // reset fetch from address 0
        step(1, 0, 0, 0);
        check("t1_ins0", bus.ins0, 32'h55667788);
        check("t1_ins0_pc", bus.ins0_pc, 0);
        check("t1_ins1", bus.ins1, 32'h11223344);
        check("t1_ins1_pc", bus.ins1_pc, 4);
        check("t1_pm_addr", bus.pm_addr_rd, 8);

        // two instructions in and out per cycle
        for (int k = 1; k <= 4; k++) begin
            step(1, 2, 0, 0);
            check("t2_ins0_pc", bus.ins0_pc, 8 * k);
            check("t2_ins1_pc", bus.ins1_pc, 8 * k + 4);
        end

        // fill, then drain one per cycle
        repeat (3) step(1, 0, 0, 0);
        check("t3_full", {bus.ins0_valid, bus.ins1_valid}, 2'b11);
        repeat (6) step(1, 1, 0, 0);

        // redirect while holding three entries
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 2, 1, 11'h040);
        check("t4_flushed", bus.ins0_valid, 0);
        check("t4_pm_addr", bus.pm_addr_rd, 11'h040);
        step(1, 0, 0, 0);
        check("t4_ins0_pc", bus.ins0_pc, 11'h040);

        // top-of-PM single-word fetch and wrap
        step(1, 0, 1, 11'(DEPTH - 4));
        step(1, 0, 0, 0);
        check("t5_one_entry", {bus.ins0_valid, bus.ins1_valid}, 2'b10);
        check("t5_ins0_pc", bus.ins0_pc, DEPTH - 4);
        check("t5_wrap", bus.pm_addr_rd, 0);
        step(1, 0, 0, 0);
        check("t5_ins1_pc", bus.ins1_pc, 0);

        // misaligned redirect halts, aligned redirect resumes
        step(1, 0, 1, 11'h041);
        check("t6_err", bus.misalign_err, 1);
        repeat (2) step(1, 0, 0, 0);
        step(1, 0, 1, 11'h044);
        check("t6_err_clr", bus.misalign_err, 0);
        step(1, 0, 0, 0);
        check("t6_ins0_pc", bus.ins0_pc, 11'h044);

        // randomized traffic with one mid-run reset
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            mx  = (q.size() < 2) ? q.size() : 2;
            r   = $urandom_range(0, 9);
            rpc = 11'($urandom_range(0, DEPTH - 1));
            if (r == 0) rpc = 11'(DEPTH - 4);
            else if (r > 2) rpc[1:0] = 2'b00;
            step($urandom_range(0, 99) < 85, 2'($urandom_range(0, mx)),
                 $urandom_range(0, 99) < 6, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
